// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Controls operand forwarding and load-use hazards for a four-stage pipeline
//   (D -> E -> M -> W). It tracks the destination register of each
//   instruction in E, M and W. From these it drives the selects of the two
//   4:1 operand muxes at the E input:
//     i0 = regfile read
//     i1 = E/M ALU result
//     i2 = M/W result
//     i3 = W writeback data
//   It also raises a one-cycle stall when a load in E feeds the D instruction.
//
// Ports:
//   clk        pipeline clock; all state changes on the rising edge
//   reset      synchronous, active-high; empties every tracking slot
//   dec_valid  D-stage instruction is valid and issuing
//   dec_rs1    D-stage source A register
//   dec_rs2    D-stage source B register
//   dec_rd     D-stage destination register
//   dec_we     D-stage instruction writes dec_rd
//   dec_load   D-stage instruction is a load (data available only at W)
//   flush      squash the D-stage instruction (branch redirect)
//   sel_a      operand-A mux select
//   sel_b      operand-B mux select
//   stall      hold PC and D; E receives a bubble
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_we,
  input  logic              dec_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic              load;
  } slot_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  // Slot 0 is the youngest producer (E), slot 2 the oldest (W).
  slot_t      r_slot [3];

  logic [2:0] w_match_a;
  logic [2:0] w_match_b;
  logic       w_rs1_zero;
  logic       w_rs2_zero;
  logic       w_stall;
  logic       w_issue;

  // A hardwired-zero source never depends on anything in flight.
  assign w_rs1_zero = (R0_ZERO != 0) && (dec_rs1 == '0);
  assign w_rs2_zero = (R0_ZERO != 0) && (dec_rs2 == '0);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign w_match_a[gi] = r_slot[gi].valid && r_slot[gi].we &&
                             (r_slot[gi].rd == dec_rs1) && !w_rs1_zero;
      assign w_match_b[gi] = r_slot[gi].valid && r_slot[gi].we &&
                             (r_slot[gi].rd == dec_rs2) && !w_rs2_zero;
    end
  endgenerate

  // Load data is not ready until W, so a consumer directly behind a load
  // waits one cycle. After that edge the load sits in M and is forwarded
  // from i2.
  assign w_stall = dec_valid && !flush && r_slot[EX].load &&
                   (w_match_a[EX] || w_match_b[EX]);

  assign w_issue = dec_valid && !w_stall && !flush;

  // Youngest producer wins. A matching load in E is never taken from i1.
  // If it did not cause a stall (no valid D, or a flush), the search simply
  // falls through to the older slots.
  function automatic logic [1:0] pick_sel(input logic [2:0] match,
                                          input logic       ex_load,
                                          input logic       st);
    logic [1:0] sel;
    sel = 2'b00;
    if (st)                       sel = 2'b00;
    else if (match[0] && !ex_load) sel = 2'b01;
    else if (match[1])             sel = 2'b10;
    else if (match[2])             sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    sel_a = pick_sel(w_match_a, r_slot[EX].load, w_stall);
    sel_b = pick_sel(w_match_b, r_slot[EX].load, w_stall);
  end

  assign stall = w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_slot[WB]  <= r_slot[MEM];
      r_slot[MEM] <= r_slot[EX];
      if (w_issue) begin
        r_slot[EX] <= '{valid: 1'b1, we: dec_we, rd: dec_rd, load: dec_load};
      end else begin
        r_slot[EX] <= '0;
      end
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Operand-forwarding and load-use hazard controller for the 16-bit core pipeline (D -> E -> M -> W).
- Tracks destination registers of the instructions in E, M and W, and drives the 2-bit select of the two 4:1 16-bit operand muxes (A and B) at the E input.
- Mux data inputs are fixed: i0 = regfile read, i1 = E/M ALU result, i2 = M/W result, i3 = W writeback data.
- Also raises a one-cycle stall for load-use dependencies.

Parameters:
- REG_AW, 4, register address width (16 architectural registers).
- R0_ZERO, 1, when 1 register 0 is hardwired zero and is never forwarded or stalled on.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all tracking state.
- dec_valid  input  1  the instruction in D is valid and issuing.
- dec_rs1  input  REG_AW  D-stage source A register.
- dec_rs2  input  REG_AW  D-stage source B register.
- dec_rd  input  REG_AW  D-stage destination register.
- dec_we  input  1  D-stage instruction writes dec_rd.
- dec_load  input  1  D-stage instruction is a load (result available only at W).
- flush  input  1  squash the D-stage instruction (branch redirect).
- sel_a  output  2  select for operand-A mux.
- sel_b  output  2  select for operand-B mux.
- stall  output  1  hold PC and D; E receives a bubble.

Behaviour:
- State: three tracking slots EX, MEM, WB. Each slot holds valid, we, rd and load.
- Reset: at the clock edge with reset=1, all slot valid bits go to 0. Effect on outputs after that edge: sel_a=sel_b=2'b00 and stall=0. Reset overrides flush, stall and dec_valid.
- Slot update every edge (reset=0):
  - WB <= MEM; MEM <= EX, unconditionally.
  - EX <= {dec_valid, dec_we, dec_rd, dec_load} if dec_valid=1 and stall=0 and flush=0.
  - Otherwise EX <= bubble (valid=0).
- A slot "matches" register r when: valid=1, we=1, rd==r, and not (R0_ZERO=1 and r==0).
- stall (combinational):
  - Asserted when dec_valid=1, flush=0, and EX matches dec_rs1 or dec_rs2 with EX.load=1.
  - Lasts exactly one cycle per hazard, because the load moves to MEM on the next edge.
  - A load that is matched from MEM does not stall. It forwards from i2, since M/W carries load data.
- sel_a (combinational on dec_rs1), priority highest first:
  - 2'b00 if stall=1.
  - 2'b01 if EX matches and EX.load=0.
  - 2'b10 if MEM matches.
  - 2'b11 if WB matches.
  - 2'b00 otherwise.
- sel_b: identical rule on dec_rs2.
- The youngest producer always wins: EX over MEM over WB.
- Latency: selects are valid in the same cycle the instruction sits in D. The consumer registers them into E alongside the operands.
- Boundary cases:
  - rs1==rs2: both selects are identical.
  - The same rd in all three slots gives 2'b01.
  - dec_valid=0: stall=0. Selects are still computed but have no effect.
  - flush=1 together with a hazard: stall=0 and EX gets a bubble.
  - Reset asserted mid-stall: stall drops after the edge. No residual forwarding from pre-reset slots.
  - An instruction with we=0 (store/branch) never becomes a forwarding source.

Test Plan:
1. Reset, then issue an ALU op writing r3, then next cycle issue rs1=r3 -> sel_a=01, sel_b=00, stall=0.
2. Issue a write to r5, one unrelated instruction, then rs2=r5 -> sel_b=10. After one more unrelated instruction, rs2=r5 -> sel_b=11. After a third, rs2=r5 -> sel_b=00.
3. Load to r7, then rs1=r7 next cycle:
   - First cycle: stall=1, sel_a=00.
   - Following cycle (same D instruction): stall=0, sel_a=10.
4. Writes to r2 in three consecutive cycles, then rs1=rs2=r2 -> sel_a=sel_b=01.
5. With R0_ZERO=1, write r0 then read rs1=r0 -> sel_a=00. The same sequence as a load -> stall=0.
6. Create a load-use hazard, assert flush in that cycle -> stall=0, and next cycle EX is empty. Separately, assert reset during a stall cycle -> after the edge stall=0 and all selects are 00.
